bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//   Upstream stage of the run detector: accepts parallel words over a valid/ready handshake and
//   shifts them out one bit at a time on x_out, which drives the detector's x input directly.
//   Each bit is held for DIV clocks, and back-to-back words stream with no gap.
//   Idle line sits at IDLE_LVL.
// PARAMETERS
//   DATA_W    8  word width in bits (>=2)
//   DIV       1  clocks per bit period (>=1)
//   MSB_FIRST 1  1: bit DATA_W-1 is sent first; 0: bit 0 is sent first
//   IDLE_LVL  0  x_out level when no word is in flight
// PORTS
//   clk       in   1       single clock, all logic posedge
//   reset     in   1       synchronous, active-high
//   in_data   in   DATA_W  word to send; sampled only on acceptance
//   in_valid  in   1       in_data is valid
//   in_ready  out  1       serializer can take a word this cycle
//   x_out     out  1       serial bit stream (to detector x)
//   x_strobe  out  1       1-cycle pulse on the first clock of each new bit period
//   busy      out  1       a word (or parity bit) is in flight
// BEHAVIOUR
//   - Reset (sync): state=IDLE, x_out=IDLE_LVL, x_strobe=0, busy=0, counters=0.
//     in_ready=0 while reset=1 and 1 on the first cycle after reset deasserts.
//   - Accept = in_valid & in_ready at a clk edge. in_data is latched into the shift register.
//   - Latency: the first bit appears on x_out, with x_strobe=1, on the cycle after acceptance.
//   - States: IDLE -> SHIFT on accept. In SHIFT, div_cnt counts 0..DIV-1. At DIV-1, bit_cnt
//     advances and the next bit is presented. After bit DATA_W-1 has been held DIV clocks:
//     if a word is accepted that same cycle, stay in SHIFT with the new word's first bit next
//     cycle; otherwise go to IDLE and x_out returns to IDLE_LVL next cycle.
//   - in_ready = IDLE | (SHIFT & last bit & div_cnt==DIV-1). This allows zero-gap streaming.
//   - busy = (state != IDLE).
//   - x_strobe = 1 exactly on div_cnt==0 of every bit period; 0 in IDLE.
//   - in_valid dropping without acceptance has no effect.
//   - in_data changes while in flight are ignored.
//   - Reset mid-word: the word is discarded and outputs take reset values next edge. No
//     partial bits after that.
//   - Widths: bit_cnt is $clog2(DATA_W+1) bits; div_cnt is max(1,$clog2(DIV)) bits.
//     Neither counter wraps past its terminal value.
// CONFIGURATION
//   SER_PARITY_EN defined:
//     - An extra PARITY state follows the last data bit.
//     - It holds the even-parity bit (^word) for DIV clocks, with x_strobe on its first clock.
//     - in_ready's early-accept point moves to the last clock of PARITY.
//     - A word then occupies DATA_W+1 bit periods.
//   SER_PARITY_EN undefined:
//     - No PARITY state and no parity logic.
//     - A word occupies exactly DATA_W bit periods.
// STRUCTURE
//   ser_pkg:
//     - state enum typedef ser_state_t {IDLE, SHIFT, PARITY}.
//     - Width helper function cnt_w(n) returning max(1,$clog2(n)).
//   Sub-module bit_tick_gen:
//     - Holds div_cnt and generates the tick / last-clock flags for a bit period.
//     - Parameter DIV; inputs clk, reset, run.
//   The top level holds the FSM, shift register, bit_cnt and handshake.
// TESTING
//   1. DIV=1, MSB_FIRST=1, accept 8'hE3 -> x_out=1,1,1,0,0,0,1,1 on cycles +1..+8, x_strobe=1
//      each cycle, x_out=0 and busy=0 at +9.
//   2. 8'hFF then 8'h00, in_valid held -> second word accepted on the last bit cycle,
//      16 contiguous bits, no IDLE cycle between words.
//   3. DIV=3, 8'hA5 -> each bit held 3 clocks, x_strobe only on the first clock of each;
//      24 busy cycles.
//   4. reset=1 during bit 4 of 8'hF0 -> next cycle x_out=IDLE_LVL, x_strobe=0, busy=0;
//      in_ready=1 the first cycle after reset drops.
//   5. SER_PARITY_EN, DIV=1, 8'h07 -> 9th bit=1; 8'h03 -> 9th bit=0; in_ready high only
//      on the parity cycle.
//   6. MSB_FIRST=0, 8'h01 -> x_out=1 then seven 0s; in_valid pulsed while busy -> not
//      accepted, stream unchanged.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and width helpers for the bit serializer.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    // Counter width for a count range of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: counts DIV clocks per bit and flags the first and last clock of each period.
module bit_tick_gen
    import ser_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick,
    output logic last
);

    localparam int CW = cnt_w(DIV);
    localparam logic [CW-1:0] LastVal = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;

    // Held at zero while idle so the first bit of a word always starts a fresh period.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!run || (div_cnt_q == LastVal)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = run && (div_cnt_q == '0);
    assign last = run && (div_cnt_q == LastVal);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the run detector; zero-gap streaming over valid/ready.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter int   DIV       = 1,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x_out,
    output logic              x_strobe,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LastBit = BW'(DATA_W - 1);

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              tick, last_clk, accept, cur_bit, end_of_word, last_bit;

    bit_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (state_q != IDLE),
        .tick (tick),
        .last (last_clk)
    );

    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LastBit);
    assign cur_bit  = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
    assign accept   = in_valid && in_ready;

`ifdef SER_PARITY_EN
    logic par_q;
    assign end_of_word = (state_q == PARITY) && last_clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^in_data;
        end
    end
`else
    assign end_of_word = last_bit && last_clk;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (last_bit && last_clk) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef SER_PARITY_EN
                if (last_clk) state_d = accept ? SHIFT : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // bit_cnt tops out at DATA_W after the last data bit; the next accept reloads it.
    always_comb begin
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            sh_d      = in_data;
            bit_cnt_d = '0;
        end else if ((state_q == SHIFT) && last_clk) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sh_d      = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        x_out    = IDLE_LVL;
        x_strobe = 1'b0;
        busy     = 1'b0;
        in_ready = !reset && ((state_q == IDLE) || end_of_word);
        unique case (state_q)
            IDLE: begin
                x_out = IDLE_LVL;
            end
            SHIFT: begin
                x_out    = cur_bit;
                x_strobe = tick;
                busy     = 1'b1;
            end
            PARITY: begin
`ifdef SER_PARITY_EN
                x_out = par_q;
`else
                x_out = IDLE_LVL;
`endif
                x_strobe = tick;
                busy     = 1'b1;
            end
            default: x_out = IDLE_LVL;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: three instances (DIV=1 MSB-first, DIV=3, LSB-first).
module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    typedef struct packed {
        logic x;
        logic s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst   [3];
    logic [7:0] din   [3];
    logic       vld   [3];
    logic       rdy   [3];
    logic       xo    [3];
    logic       xs    [3];
    logic       bsy   [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serializer #(.DATA_W(8), .DIV(1), .MSB_FIRST(1), .IDLE_LVL(1'b0)) u0 (
        .clk(clk), .reset(rst[0]), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .x_out(xo[0]), .x_strobe(xs[0]), .busy(bsy[0])
    );
    bit_serializer #(.DATA_W(8), .DIV(3), .MSB_FIRST(1), .IDLE_LVL(1'b0)) u1 (
        .clk(clk), .reset(rst[1]), .in_data(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .x_out(xo[1]), .x_strobe(xs[1]), .busy(bsy[1])
    );
    bit_serializer #(.DATA_W(8), .DIV(1), .MSB_FIRST(0), .IDLE_LVL(1'b0)) u2 (
        .clk(clk), .reset(rst[2]), .in_data(din[2]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .x_out(xo[2]), .x_strobe(xs[2]), .busy(bsy[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic exp_t qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every busy cycle must match the next expected bit/strobe pair.
    task automatic mon_step(input int k);
        exp_t e;
        if (bsy[k] === 1'b1) begin
            if (qsize(k) == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL busy_unexpected[%0d]: got busy=1 expected no word in flight", k);
            end else begin
                e = qpop(k);
                check($sformatf("x_out[%0d]", k), 32'(xo[k]), 32'(e.x));
                check($sformatf("x_strobe[%0d]", k), 32'(xs[k]), 32'(e.s));
            end
        end else begin
            check($sformatf("idle_x_out[%0d]", k), 32'(xo[k]), 32'(1'b0));
            check($sformatf("idle_strobe[%0d]", k), 32'(xs[k]), 32'(1'b0));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) mon_step(k);
        end
    end

    task automatic push_word(input int k, input logic [7:0] w, input int div, input bit msb,
                             input bit par);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = msb ? w[7-i] : w[i];
            for (int d = 0; d < div; d++) qpush(k, '{x: b, s: (d == 0)});
        end
`ifdef SER_PARITY_EN
        for (int d = 0; d < div; d++) qpush(k, '{x: par, s: (d == 0)});
`else
        if (par) begin end
`endif
    endtask

    // Offer a word, wait for acceptance; returns at #1 after the accepting edge.
    task automatic send(input int k, input logic [7:0] w, input int div, input bit msb,
                        input bit par, output int acc);
        bit r;
        bit got;
        got   = 1'b0;
        acc   = -1;
        din[k] = w;
        vld[k] = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            r = rdy[k];
            @(posedge clk);
            #1;
            if (r) got = 1'b1;
        end
        if (got) begin
            acc = cyc;
            push_word(k, w, div, msb, par);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout[%0d]: got no in_ready expected acceptance of %0h", k, w);
        end
        vld[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int exp_n, input int exp_ridx);
        int n;
        int rc;
        int ridx;
        n    = 0;
        rc   = 0;
        ridx = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bsy[k] !== 1'b1) break;
            if (rdy[k] === 1'b1) begin
                rc++;
                ridx = n;
            end
            n++;
        end
        check($sformatf("busy_cycles[%0d]", k), n, exp_n);
        check($sformatf("ready_count[%0d]", k), rc, 1);
        check($sformatf("ready_index[%0d]", k), ridx, exp_ridx);
        check($sformatf("drained[%0d]", k), qsize(k), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a1;
        int a2;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            vld[k] = 1'b0;
            din[k] = 8'h00;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ready[%0d]", k), 32'(rdy[k]), 32'(1'b0));
            check($sformatf("rst_busy[%0d]", k), 32'(bsy[k]), 32'(1'b0));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("ready_after_rst[%0d]", k), 32'(rdy[k]), 1);
        @(posedge clk);
        #1;

        // Single word, DIV=1, MSB first: 1,1,1,0,0,0,1,1 then idle.
        send(0, 8'hE3, 1, 1'b1, 1'b1, a1);
        wait_done(0, NB, NB - 1);

        // Back-to-back words with in_valid held: second accept lands on the last bit.
        send(0, 8'hFF, 1, 1'b1, 1'b0, a1);
        send(0, 8'h00, 1, 1'b1, 1'b0, a2);
        check("gap_accept_cycles", a2 - a1, NB);
        wait_done(0, NB, NB - 1);

        // DIV=3: each bit held three clocks, strobe on the first.
        send(1, 8'hA5, 3, 1'b1, 1'b0, a1);
        wait_done(1, 3 * NB, 3 * NB - 1);

        // Reset during bit 4 of 8'hF0.
        send(0, 8'hF0, 1, 1'b1, 1'b0, a1);
        repeat (4) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(negedge clk);
        check("ready_during_rst", 32'(rdy[0]), 32'(1'b0));
        @(posedge clk);
        #1;
        q0.delete();
        rst[0] = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bsy[0]), 32'(1'b0));
        check("midrst_x_out", 32'(xo[0]), 32'(1'b0));
        check("midrst_strobe", 32'(xs[0]), 32'(1'b0));
        check("midrst_ready", 32'(rdy[0]), 32'(1'b1));
        @(posedge clk);
        #1;

        // LSB first; a valid pulse while busy must not be taken.
        send(2, 8'h01, 1, 1'b0, 1'b1, a1);
        @(posedge clk);
        #1;
        din[2] = 8'hAA;
        vld[2] = 1'b1;
        @(negedge clk);
        check("ready_while_busy", 32'(rdy[2]), 32'(1'b0));
        @(posedge clk);
        #1;
        vld[2] = 1'b0;
        wait_done(2, NB - 2, NB - 3);

`ifdef SER_PARITY_EN
        send(0, 8'h07, 1, 1'b1, 1'b1, a1);
        wait_done(0, 9, 8);
        send(0, 8'h03, 1, 1'b1, 1'b0, a1);
        wait_done(0, 9, 8);
`endif

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("final_drained[%0d]", k), qsize(k), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
